dino_motion: RTL and testbench



---
 rtl/dino_pkg.sv | 20 ++
 rtl/dino_motion_if.sv | 15 +
 rtl/dino_tick_gen.sv | 24 ++
 rtl/dino_motion.sv | 134 +++++++++++++
 tb/tb_dino_motion.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/dino_pkg.sv
// rtl/dino_pkg.sv - shared dino game encodings, sprite geometry and motion-state enum
package dino_pkg;
   localparam logic [1:0] GAME_INIT  = 2'd0;
   localparam logic [1:0] GAME_START = 2'd1;
   localparam logic [1:0] GAME_END   = 2'd2;
   localparam logic [1:0] GAME_RESET = 2'd3;

   localparam logic STAND_BEHAVIOR = 1'b1;
   localparam logic SIT_BEHAVIOR   = 1'b0;

   localparam int         DINO_HEIGHT = 49;
   localparam logic [9:0] GROUND      = 10'd298;
   localparam logic [9:0] DINO_X      = 10'd40;

   typedef enum logic [1:0] {
      ON_GROUND = 2'd0,
      RISING    = 2'd1,
      FALLING   = 2'd2
   } motion_state_e;
endpackage

// File: rtl/dino_motion_if.sv
// rtl/dino_motion_if.sv - button/game-state inputs and sprite-motion outputs of the dino motion controller
interface dino_motion_if;
   logic       jump_btn;
   logic       duck_btn;
   logic [1:0] game_state;
   logic [9:0] pos;
   logic       dino_behavior;
   logic       airborne;
   logic       tick;

   modport master (output jump_btn, duck_btn, game_state,
                   input  pos, dino_behavior, airborne, tick);
   modport slave  (input  jump_btn, duck_btn, game_state,
                   output pos, dino_behavior, airborne, tick);
endinterface

// File: rtl/dino_tick_gen.sv
// rtl/dino_tick_gen.sv - free-running physics tick, one-cycle pulse every TICK_CYCLES clocks
module dino_tick_gen #(
   parameter int TICK_CYCLES = 1666667
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);
   localparam int            CW   = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
   localparam logic [CW-1:0] LAST = CW'(TICK_CYCLES - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign tick = (cnt_q == LAST);
endmodule

// File: rtl/dino_motion.sv
// rtl/dino_motion.sv - dino vertical motion: jump arc under gravity, fast-fall on duck, exact landing
module dino_motion
   import dino_pkg::*;
#(
   parameter int TICK_CYCLES = 1666667,
   parameter int MIN_POS     = DINO_HEIGHT + 1,
   parameter int JUMP_V0     = 12,
   parameter int GRAVITY     = 1,
   parameter int VMAX        = 15
) (
   input logic          clk,
   input logic          rst,
   dino_motion_if.slave mif
);
   motion_state_e state_q, state_d;
   logic [9:0]    pos_q, pos_d;
   logic [4:0]    vel_q, vel_d;
   logic          jump_req_q, jump_req_d;
   logic          jump_prev_q, jump_prev_d;
   logic          behavior_q, behavior_d;
   logic          tick;

   logic [10:0]   pos_x, vel_x, rise_pos, fall_step, fall_v, fall_pos;
   logic          jump_edge;

   dino_tick_gen #(.TICK_CYCLES(TICK_CYCLES)) u_tick (
      .clk  (clk),
      .rst  (rst),
      .tick (tick)
   );

   // 11-bit candidates so neither the upward subtract nor the fall add can wrap
   always_comb begin
      pos_x     = {1'b0, pos_q};
      vel_x     = {6'd0, vel_q};
      rise_pos  = pos_x - vel_x;
      fall_step = mif.duck_btn ? 11'(2 * GRAVITY) : 11'(GRAVITY);
      fall_v    = vel_x + fall_step;
      if (fall_v > 11'(VMAX)) fall_v = 11'(VMAX);
      fall_pos  = pos_x + fall_v;
   end

   assign jump_edge = mif.jump_btn & ~jump_prev_q;

   always_comb begin
      state_d     = state_q;
      pos_d       = pos_q;
      vel_d       = vel_q;
      jump_req_d  = jump_req_q;
      jump_prev_d = mif.jump_btn;
      behavior_d  = (state_q == ON_GROUND && mif.duck_btn && mif.game_state == GAME_START)
                    ? SIT_BEHAVIOR : STAND_BEHAVIOR;

      case (mif.game_state)
         GAME_START: begin
            if (jump_edge && state_q == ON_GROUND && !mif.duck_btn) jump_req_d = 1'b1;
            if (tick) begin
               unique case (state_q)
                  ON_GROUND: begin
                     if (jump_req_q) begin
                        pos_d      = 10'(pos_x - 11'(JUMP_V0));
                        vel_d      = 5'(JUMP_V0 - GRAVITY);
                        state_d    = RISING;
                        jump_req_d = 1'b0;
                     end
                  end
                  RISING: begin
                     if (mif.duck_btn) begin
                        state_d = FALLING;
                        vel_d   = '0;
                     end else if (rise_pos < 11'(MIN_POS)) begin
                        pos_d   = 10'(MIN_POS);
                        state_d = FALLING;
                        vel_d   = '0;
                     end else begin
                        pos_d = rise_pos[9:0];
                        if (vel_x <= 11'(GRAVITY)) begin
                           state_d = FALLING;
                           vel_d   = '0;
                        end else begin
                           vel_d = vel_q - 5'(GRAVITY);
                        end
                     end
                  end
                  FALLING: begin
                     if (fall_pos >= {1'b0, GROUND}) begin
                        pos_d   = GROUND;
                        vel_d   = '0;
                        state_d = ON_GROUND;
                     end else begin
                        pos_d = fall_pos[9:0];
                        vel_d = fall_v[4:0];
                     end
                  end
                  default: state_d = ON_GROUND;
               endcase
            end
         end
         GAME_END: begin
            jump_req_d = 1'b0;
         end
         default: begin
            // INIT and RESET both pin the sprite to its resting condition
            state_d    = ON_GROUND;
            pos_d      = GROUND;
            vel_d      = '0;
            jump_req_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ON_GROUND;
         pos_q       <= GROUND;
         vel_q       <= '0;
         jump_req_q  <= 1'b0;
         jump_prev_q <= 1'b0;
         behavior_q  <= STAND_BEHAVIOR;
      end else begin
         state_q     <= state_d;
         pos_q       <= pos_d;
         vel_q       <= vel_d;
         jump_req_q  <= jump_req_d;
         jump_prev_q <= jump_prev_d;
         behavior_q  <= behavior_d;
      end
   end

   assign mif.pos           = pos_q;
   assign mif.dino_behavior = behavior_q;
   assign mif.airborne      = (state_q != ON_GROUND);
   assign mif.tick          = tick;
endmodule

// File: tb/tb_dino_motion.sv
// tb/tb_dino_motion.sv - randomized and scripted checks of dino_motion against a tick-level motion model
module tb_dino_motion;
   import dino_pkg::*;

   localparam int TC = 4;

   logic clk;
   logic rst;
   int   total;
   int   bad;

   dino_motion_if mif ();

   dino_motion #(.TICK_CYCLES(TC)) dut (
      .clk (clk),
      .rst (rst),
      .mif (mif)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // model: phase 0 ground, 1 up, 2 down; m_cnt is the cycle position inside a tick period
   int m_pos, m_vel, m_phase, m_cnt;
   bit m_req, m_prev, m_beh;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_edge();
      bit tk, set_req, consumed, duck, jump;
      int gs, v;
      duck = mif.duck_btn;
      jump = mif.jump_btn;
      gs   = int'(mif.game_state);
      if (rst) begin
         m_pos = 298; m_vel = 0; m_phase = 0; m_req = 0; m_prev = 0; m_beh = 1; m_cnt = 0;
         return;
      end
      tk       = (m_cnt == TC - 1);
      m_cnt    = (m_cnt + 1) % TC;
      m_beh    = !(m_phase == 0 && duck && gs == 1);
      set_req  = jump && !m_prev && m_phase == 0 && !duck;
      consumed = 0;
      if (gs == 1) begin
         if (tk) begin
            if (m_phase == 0 && m_req) begin
               m_pos = m_pos - 12; m_vel = 11; m_phase = 1; consumed = 1;
            end else if (m_phase == 1) begin
               if (duck) begin
                  m_phase = 2; m_vel = 0;
               end else if (m_pos - m_vel < 50) begin
                  m_pos = 50; m_phase = 2; m_vel = 0;
               end else begin
                  m_pos = m_pos - m_vel;
                  if (m_vel <= 1) begin m_phase = 2; m_vel = 0; end
                  else m_vel = m_vel - 1;
               end
            end else if (m_phase == 2) begin
               v = m_vel + (duck ? 2 : 1);
               if (v > 15) v = 15;
               if (m_pos + v >= 298) begin m_pos = 298; m_vel = 0; m_phase = 0; end
               else begin m_pos = m_pos + v; m_vel = v; end
            end
         end
         m_req = consumed ? 1'b0 : (m_req | set_req);
      end else if (gs == 2) begin
         m_req = 0;
      end else begin
         m_pos = 298; m_vel = 0; m_phase = 0; m_req = 0;
      end
      m_prev = jump;
   endtask

   task automatic step();
      model_edge();
      @(posedge clk);
      #1;
      check("pos", 32'(mif.pos), 32'(m_pos));
      check("behavior", 32'(mif.dino_behavior), 32'(m_beh));
      check("airborne", 32'(mif.airborne), 32'(m_phase != 0));
      check("tick", 32'(mif.tick), 32'(m_cnt == TC - 1));
   endtask

   // advance through the next tick cycle and the edge that applies it
   task automatic do_tick();
      for (int i = 0; i < TC && m_cnt != TC - 1; i++) step();
      step();
   endtask

   task automatic pulse_jump();
      mif.jump_btn = 1'b1;
      step();
      mif.jump_btn = 1'b0;
   endtask

   int arc [24] = '{286, 275, 265, 256, 248, 241, 235, 230, 226, 223, 221, 220,
                    221, 223, 226, 230, 235, 241, 248, 256, 265, 275, 286, 298};
   int duck_fall [6] = '{258, 262, 268, 276, 286, 298};

   initial begin
      total = 0;
      bad   = 0;
      rst   = 1'b1;
      mif.jump_btn   = 1'b0;
      mif.duck_btn   = 1'b0;
      mif.game_state = GAME_INIT;
      step();
      step();
      check("reset_pos", 32'(mif.pos), 32'd298);
      check("reset_behavior", 32'(mif.dino_behavior), 32'd1);
      check("reset_airborne", 32'(mif.airborne), 32'd0);
      check("reset_tick", 32'(mif.tick), 32'd0);
      rst = 1'b0;

      for (int k = 0; k < 20; k++) begin
         mif.jump_btn = k[0];
         do_tick();
      end
      mif.jump_btn = 1'b0;
      check("init_pos", 32'(mif.pos), 32'd298);
      check("init_airborne", 32'(mif.airborne), 32'd0);

      mif.game_state = GAME_START;
      step();
      pulse_jump();
      for (int k = 0; k < 24; k++) begin
         do_tick();
         check("arc_pos", 32'(mif.pos), 32'(arc[k]));
         check("arc_airborne", 32'(mif.airborne), 32'(k < 23));
      end

      mif.duck_btn = 1'b1;
      step();
      check("duck_sit", 32'(mif.dino_behavior), 32'd0);
      pulse_jump();
      for (int k = 0; k < 10; k++) do_tick();
      check("duck_nojump_pos", 32'(mif.pos), 32'd298);
      check("duck_nojump_air", 32'(mif.airborne), 32'd0);
      mif.duck_btn = 1'b0;
      step();
      check("duck_release", 32'(mif.dino_behavior), 32'd1);

      pulse_jump();
      for (int k = 0; k < 4; k++) do_tick();
      check("ff_pre", 32'(mif.pos), 32'd256);
      mif.duck_btn = 1'b1;
      do_tick();
      check("ff_hold", 32'(mif.pos), 32'd256);
      check("ff_hold_air", 32'(mif.airborne), 32'd1);
      for (int k = 0; k < 6; k++) begin
         do_tick();
         check("ff_pos", 32'(mif.pos), 32'(duck_fall[k]));
      end
      check("ff_landed", 32'(mif.airborne), 32'd0);
      mif.duck_btn = 1'b0;
      step();

      pulse_jump();
      for (int k = 0; k < 6; k++) do_tick();
      check("end_pre", 32'(mif.pos), 32'd241);
      mif.game_state = GAME_END;
      mif.duck_btn   = 1'b1;
      for (int k = 0; k < 10; k++) do_tick();
      check("end_pos", 32'(mif.pos), 32'd241);
      check("end_behavior", 32'(mif.dino_behavior), 32'd1);
      mif.duck_btn   = 1'b0;
      mif.game_state = GAME_RESET;
      step();
      check("rs_pos", 32'(mif.pos), 32'd298);
      check("rs_airborne", 32'(mif.airborne), 32'd0);
      mif.game_state = GAME_START;
      step();

      pulse_jump();
      for (int k = 0; k < 3; k++) do_tick();
      check("rst_pre", 32'(mif.pos), 32'd265);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("rst_pos", 32'(mif.pos), 32'd298);
      check("rst_airborne", 32'(mif.airborne), 32'd0);
      check("rst_tick0", 32'(mif.tick), 32'd0);
      step();
      step();
      check("rst_tick2", 32'(mif.tick), 32'd0);
      step();
      check("rst_tick3", 32'(mif.tick), 32'd1);

      for (int n = 0; n < 4000; n++) begin
         if ($urandom_range(0, 79) == 0) begin
            case ($urandom_range(0, 15))
               0:       mif.game_state = GAME_INIT;
               1:       mif.game_state = GAME_END;
               2:       mif.game_state = GAME_RESET;
               default: mif.game_state = GAME_START;
            endcase
         end
         if ($urandom_range(0, 5) == 0)  mif.jump_btn = ~mif.jump_btn;
         if ($urandom_range(0, 29) == 0) mif.duck_btn = ~mif.duck_btn;
         rst = ($urandom_range(0, 499) == 0);
         step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
